// File: rtl/mig_eval_pkg.sv
// Shared constants for the sequential MIG evaluator.
// Holds the FSM encoding, the node index map and the config word field positions.
package mig_eval_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EVAL = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Node index space: constant zero, then primary inputs, then gate results
  localparam int CONST0_IDX = 0;
  localparam int INPUT_BASE = 1;

  function automatic int gate_base(input int num_inputs);
    return INPUT_BASE + num_inputs;
  endfunction

  // Gate word: operand k occupies {inv_k, sel_k}, packed LSB first
  function automatic int op_sel_lsb(input int sel_w, input int k);
    return k * (sel_w + 1);
  endfunction

  function automatic int op_inv_bit(input int sel_w, input int k);
    return k * (sel_w + 1) + sel_w;
  endfunction

  // Control word: {num_gates, out_inv, out_sel}, packed LSB first
  function automatic int ctl_inv_bit(input int sel_w);
    return sel_w;
  endfunction

  function automatic int ctl_cnt_lsb(input int sel_w);
    return sel_w + 1;
  endfunction

endpackage

// File: rtl/mig_maj_node.sv
// Three-input majority with a per-operand complement.
// Purely combinational so it can be replicated for parallel evaluation lanes.
module mig_maj_node (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic inv_a,
  input  logic inv_b,
  input  logic inv_c,
  output logic maj
);

  logic a_eff;
  logic b_eff;
  logic c_eff;

  // Apply the complement bits, then take the majority
  always_comb begin
    a_eff = a ^ inv_a;
    b_eff = b ^ inv_b;
    c_eff = c ^ inv_c;
    maj   = (a_eff & b_eff) | (a_eff & c_eff) | (b_eff & c_eff);
  end

endmodule

// File: rtl/mig_eval_seq.sv
// Runtime-programmable majority-inverter-graph evaluator.
// A register-based gate program is loaded while idle; each accepted input
// vector is then evaluated one gate per clock and the selected node is
// presented on y with a valid/ready handshake.
//
//   state | meaning
//   IDLE  | ready for a vector; config writes accepted here only
//   EVAL  | evaluating gate[cnt] this cycle
//   DONE  | result valid on y, waiting for out_ready
module mig_eval_seq
  import mig_eval_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  parameter  int MAX_GATES  = 8,
  localparam int NODES      = 1 + NUM_INPUTS + MAX_GATES,
  localparam int SEL_W      = $clog2(NODES),
  localparam int CNT_W      = $clog2(MAX_GATES + 1),
  localparam int CFG_W      = 3 * (SEL_W + 1),
  localparam int ADDR_W     = $clog2(MAX_GATES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [CFG_W-1:0]      cfg_data,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_INPUTS-1:0] x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  y
);

  localparam int GB    = gate_base(NUM_INPUTS);
  localparam int PAD   = 2 ** SEL_W;
  localparam int CTL_W = SEL_W + 1 + CNT_W;
  localparam logic [ADDR_W-1:0] ADDR_CTL = ADDR_W'(MAX_GATES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_GATES);

  logic [CFG_W-1:0]      gate_cfg [MAX_GATES];
  logic [CTL_W-1:0]      ctl_q;
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_INPUTS-1:0] x_q;
  logic [MAX_GATES-1:0]  gate_q;
  logic                  y_q;
  logic                  cfg_err_q;

  logic [SEL_W-1:0]      out_sel;
  logic                  out_inv;
  logic [CNT_W-1:0]      ng_raw;
  logic [CNT_W-1:0]      ng_eff;
  logic [CFG_W-1:0]      cur_word;
  logic [MAX_GATES-1:0]  gate_vis;
  logic [MAX_GATES-1:0]  gate_next;
  logic [PAD-1:0]        eval_nodes;
  logic [PAD-1:0]        y_nodes;
  logic [SEL_W-1:0]      op_sel [3];
  logic [2:0]            op_inv;
  logic [2:0]            op_val;
  logic                  maj_out;
  logic                  y_next;

  // Decode the control word; oversize gate counts saturate at capacity
  always_comb begin
    out_sel = ctl_q[SEL_W-1:0];
    out_inv = ctl_q[ctl_inv_bit(SEL_W)];
    ng_raw  = ctl_q[ctl_cnt_lsb(SEL_W) +: CNT_W];
    ng_eff  = (ng_raw > CNT_MAX) ? CNT_MAX : ng_raw;
  end

  // Fetch the gate word addressed by cnt
  always_comb begin
    cur_word = '0;
    for (int g = 0; g < MAX_GATES; g++) begin
      if (cnt == CNT_W'(g)) cur_word = gate_cfg[g];
    end
  end

  // Operand node view: only gates strictly before cnt are visible, and the
  // zero padding above NODES makes out-of-range selects read 0
  always_comb begin
    for (int g = 0; g < MAX_GATES; g++) begin
      gate_vis[g] = gate_q[g] & (CNT_W'(g) < cnt);
    end
    eval_nodes = '0;
    eval_nodes[CONST0_IDX] = 1'b0;
    eval_nodes[INPUT_BASE +: NUM_INPUTS] = x_q;
    eval_nodes[GB +: MAX_GATES] = gate_vis;
  end

  // Split the gate word into three operand selects and complement bits
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      op_sel[k] = cur_word[op_sel_lsb(SEL_W, k) +: SEL_W];
      op_inv[k] = cur_word[op_inv_bit(SEL_W, k)];
      op_val[k] = eval_nodes[op_sel[k]];
    end
  end

  mig_maj_node u_maj (
    .a     (op_val[0]),
    .b     (op_val[1]),
    .c     (op_val[2]),
    .inv_a (op_inv[0]),
    .inv_b (op_inv[1]),
    .inv_c (op_inv[2]),
    .maj   (maj_out)
  );

  // Node registers with the current gate result folded in
  always_comb begin
    gate_next = gate_q;
    for (int g = 0; g < MAX_GATES; g++) begin
      if (cnt == CNT_W'(g)) gate_next[g] = maj_out;
    end
  end

  // Output value as it will be registered on DONE entry; from IDLE (zero
  // gates) the raw input vector is used since x_q is only being loaded
  always_comb begin
    y_nodes = '0;
    if (state == ST_IDLE) begin
      y_nodes[INPUT_BASE +: NUM_INPUTS] = x;
    end else begin
      y_nodes[INPUT_BASE +: NUM_INPUTS] = x_q;
      y_nodes[GB +: MAX_GATES] = gate_next;
    end
    y_next = y_nodes[out_sel] ^ out_inv;
  end

  // Config register file: writes land only while idle and in range
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < MAX_GATES; g++) gate_cfg[g] <= '0;
      ctl_q <= '0;
    end else if (cfg_we && (state == ST_IDLE)) begin
      for (int g = 0; g < MAX_GATES; g++) begin
        if (cfg_addr == ADDR_W'(g)) gate_cfg[g] <= cfg_data;
      end
      if (cfg_addr == ADDR_CTL) ctl_q <= cfg_data[CTL_W-1:0];
    end
  end

  // Rejected-write flag, one cycle after the offending strobe
  always_ff @(posedge clk) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_we && ((state != ST_IDLE) || (cfg_addr > ADDR_CTL));
  end

  // Sequencer: accept, step through gates, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      x_q    <= '0;
      gate_q <= '0;
      y_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_q    <= x;
            gate_q <= '0;
            cnt    <= '0;
            if (ng_eff == '0) begin
              state <= ST_DONE;
              y_q   <= y_next;
            end else begin
              state <= ST_EVAL;
            end
          end
        end
        ST_EVAL: begin
          gate_q <= gate_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == ng_eff - CNT_W'(1)) begin
            state <= ST_DONE;
            y_q   <= y_next;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign y         = y_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_mig_eval_seq.sv
// Directed bench for mig_eval_seq with hand-computed expectations.
module tb_mig_eval_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [14:0] cfg_data;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  x;
  logic        out_valid;
  logic        out_ready;
  logic        y;

  int checks = 0;
  int errors = 0;

  int   lat;
  logic yv;
  logic err;

  always #5 clk = ~clk;

  mig_eval_seq #(.NUM_INPUTS(4), .MAX_GATES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Called at a negedge; returns at the negedge where cfg_err reflects the write
  task automatic cfg_write(input logic [3:0] a, input logic [14:0] d, output logic e);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    e = cfg_err;
  endtask

  task automatic cfg_idle(input logic [3:0] a, input logic [14:0] d, output logic e);
    wait_idle();
    cfg_write(a, d, e);
  endtask

  // lat counts negedges after the accept edge until out_valid is seen
  task automatic run_vec(input logic [3:0] xv, output int l, output logic yo);
    wait_idle();
    in_valid = 1'b1;
    x = xv;
    @(negedge clk);
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 40) begin
      @(negedge clk);
      l++;
    end
    yo = y;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; x = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_cfg_err", cfg_err, 0);

    run_vec(4'b1111, lat, yv);
    chk("rst_cfg_lat", lat, 1);
    chk("rst_cfg_y", yv, 0);

    cfg_idle(4'd9, 15'h041, err);
    chk("bad_addr_err", err, 1);
    @(negedge clk);
    chk("bad_addr_err_pulse", cfg_err, 0);

    // AND: M(x0,x1,0)
    cfg_idle(4'd0, 15'h041, err);
    chk("and_g0_err", err, 0);
    cfg_idle(4'd8, 15'h025, err);
    run_vec(4'b0011, lat, yv);
    chk("and_11_lat", lat, 2);
    chk("and_11_y", yv, 1);
    run_vec(4'b0001, lat, yv);
    chk("and_01_lat", lat, 2);
    chk("and_01_y", yv, 0);

    // Chain: g1 = M(g0,x2,~0) = g0 | x2
    cfg_idle(4'd1, 15'h4065, err);
    cfg_idle(4'd8, 15'h046, err);
    run_vec(4'b0100, lat, yv);
    chk("chain_0100_lat", lat, 3);
    chk("chain_0100_y", yv, 1);
    run_vec(4'b0000, lat, yv);
    chk("chain_0000_y", yv, 0);
    run_vec(4'b0011, lat, yv);
    chk("chain_0011_y", yv, 1);

    // NAND through output invert
    cfg_idle(4'd8, 15'h035, err);
    run_vec(4'b0011, lat, yv);
    chk("nand_11_y", yv, 0);
    run_vec(4'b0010, lat, yv);
    chk("nand_10_y", yv, 1);

    // Zero gates, output = x3
    cfg_idle(4'd8, 15'h004, err);
    run_vec(4'b1000, lat, yv);
    chk("pass_x3_lat", lat, 1);
    chk("pass_x3_y1", yv, 1);
    run_vec(4'b0111, lat, yv);
    chk("pass_x3_y0", yv, 0);

    // Out-of-range output select reads 0, inverted to 1
    cfg_idle(4'd8, 15'h01E, err);
    run_vec(4'b1111, lat, yv);
    chk("oor_sel_y", yv, 1);

    // num_gates = 15 saturates at 8
    cfg_idle(4'd8, 15'h1E5, err);
    run_vec(4'b0011, lat, yv);
    chk("clamp_lat", lat, 9);
    chk("clamp_y", yv, 1);

    // Backpressure and write rejected in DONE
    cfg_idle(4'd8, 15'h025, err);
    out_ready = 1'b0;
    run_vec(4'b0011, lat, yv);
    chk("bp_lat", lat, 2);
    chk("bp_y", yv, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_y", y, 1);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    cfg_write(4'd8, 15'h004, err);
    chk("done_write_err", err, 1);
    chk("done_write_y", y, 1);
    chk("done_write_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    run_vec(4'b0011, lat, yv);
    chk("cfg_kept_lat", lat, 2);
    chk("cfg_kept_y", yv, 1);

    // Forward/self references: g0 = M(~g1,x0,0), g1 = M(g1,g0,x1)
    cfg_idle(4'd0, 15'h036, err);
    cfg_idle(4'd1, 15'h08A6, err);
    cfg_idle(4'd8, 15'h046, err);
    run_vec(4'b1111, lat, yv);
    chk("fwd_1111_lat", lat, 3);
    chk("fwd_1111_y", yv, 1);
    run_vec(4'b0001, lat, yv);
    chk("fwd_0001_y", yv, 0);
    run_vec(4'b0011, lat, yv);
    chk("fwd_0011_y", yv, 1);
    run_vec(4'b0000, lat, yv);
    chk("fwd_0000_y", yv, 0);

    // Reset during EVAL
    wait_idle();
    in_valid = 1'b1;
    x = 4'b1111;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_eval_in_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end
    run_vec(4'b1111, lat, yv);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_y", yv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mig_eval_seq.md
Name: mig_eval_seq

Overview:
- Programmable, sequential majority-inverter-graph (MIG) evaluator.
- Replaces fixed per-function MIG netlists with one runtime-configurable engine. Up to MAX_GATES 3-input majority nodes, each operand optionally complemented, over NUM_INPUTS primary inputs.
- Evaluates one gate per clock through a valid/ready pipeline slot.
- Sits after the exact-synthesis result loader: the loader writes the gate program, then input vectors stream through.

Parameters:
- NUM_INPUTS, 4, number of primary inputs x.
- MAX_GATES, 8, capacity of the gate program.
- Derived, not overridable:
  - NODES = 1+NUM_INPUTS+MAX_GATES
  - SEL_W = $clog2(NODES)
  - CNT_W = $clog2(MAX_GATES+1)
  - CFG_W = 3*(SEL_W+1)
  - ADDR_W = $clog2(MAX_GATES+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  ADDR_W  0..MAX_GATES-1 = gate slot; MAX_GATES = control word
- cfg_data  in  CFG_W  gate or control word
- cfg_err  out  1  one-cycle pulse: write rejected
- in_valid  in  1  input vector valid
- in_ready  out  1  engine can accept a vector
- x  in  NUM_INPUTS  input vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  1  function value

Behaviour:
- **Interface:** one clock, `clk`. Reset `rst` is synchronous and active-high.
- **Node index space:**
  - 0 = constant 0
  - 1..NUM_INPUTS = x[i-1]
  - NUM_INPUTS+1+g = result of gate g
- **Gate word layout (LSB first):** {sel0[SEL_W], inv0, sel1[SEL_W], inv1, sel2[SEL_W], inv2}.
  - Gate value = MAJ(n[sel0]^inv0, n[sel1]^inv1, n[sel2]^inv2).
- **Control word layout (LSB first):** {out_sel[SEL_W], out_inv, num_gates[CNT_W]}. Remaining upper bits are ignored.
  - num_gates > MAX_GATES is clamped to MAX_GATES.
- **Config RAM:** register-based.
  - Reset value: all gate words 0, control word 0. So y = 0 and num_gates = 0.
  - Writes are accepted only in IDLE.
  - cfg_we in any other state, or with cfg_addr > MAX_GATES, is dropped and pulses cfg_err for one cycle the next cycle.
- **Node value registers:** gate result bits, cleared on every input accept.
  - An operand selecting gate h ≥ current gate g (forward or self reference) reads 0. No combinational loop is allowed.
  - Out-of-range sel (≥ NODES) reads 0.
- **FSM states:** IDLE, EVAL, DONE.
  - IDLE: in_ready = 1. On in_valid, latch x into x_q, clear node regs, cnt = 0. Go to EVAL if num_gates > 0, else DONE.
  - EVAL: in_ready = 0. Each cycle compute gate[cnt] from x_q and node regs, store to node reg cnt, cnt++. After gate num_gates-1, go to DONE.
  - DONE: out_valid = 1, y = n[out_sel]^out_inv, registered on entry. Return to IDLE on out_ready; no same-cycle re-accept.
- **Latency:** out_valid asserts num_gates+1 cycles after the accept edge.
- **Throughput:** 1 vector per num_gates+2 cycles with out_ready held high.
- **Backpressure:** y and out_valid hold stable while out_ready = 0. in_ready stays 0.
- **Config stability:** config cannot change during EVAL or DONE, because writes are only accepted in IDLE.
- **Reset values:**
  - FSM → IDLE, cnt = 0, node regs = 0.
  - Outputs: out_valid = 0, y = 0, in_ready = 1 (first cycle after reset), cfg_err = 0.
- **Reset mid-EVAL/DONE:** the result is discarded and the config is reset. No out_valid is emitted for the aborted vector.

Decomposition:
- Package mig_eval_pkg: FSM state enum; field offset/width functions for the gate and control words; node-index constants (CONST0_IDX = 0, INPUT_BASE = 1, GATE_BASE(NUM_INPUTS)).
- Sub-module mig_maj_node: purely combinational; takes 3 operands plus 3 invert bits and returns the majority. This is the single reuse point for future parallel-lane variants.

Test Plan:
- **AND:** write gate0 = 0x041 (M(x0,x1,0)) and control = 0x025 (out_sel = 5, num_gates = 1); x = 4'b0011 → y = 1 with out_valid 2 cycles after accept; x = 4'b0001 → y = 0.
- **Two-gate chain:** gate0 = 0x041, gate1 = 0x4065 (M(g0,x2,~0) = OR), control = 0x046; x = 4'b0100 → y = 1 at latency 3; x = 4'b0000 → y = 0.
- **Output invert, zero gates:** control = 0x035 with gate0 = 0x041 (NAND); x = 4'b0011 → y = 0. Then control = 0x004 (num_gates = 0, out_sel = x3); x = 4'b1000 → y = 1 at latency 1.
- **Backpressure and rejected write:**
  - Hold out_ready = 0 for 5 cycles → y, out_valid stable; in_ready = 0.
  - cfg_we during DONE → cfg_err pulses, result unchanged.
- **Forward reference:** gate0 sel0 = 6 (gate1); feed x = 4'b1111 → operand reads 0; y matches the model.
- **Reset:** assert rst during EVAL → next cycle IDLE, in_ready = 1, out_valid = 0. A fresh vector yields y = 0, because config was cleared.
